// File: rtl/fsgnj_exec_stage.sv
// Sign-injection execute stage (fsgnj / fsgnjn / fsgnjx) feeding an in-order result FIFO.
// Optional macro FSGNJ_EXEC_PERF_EN adds release and stall counters (perf_cnt, perf_stall).
module fsgnj_exec_stage #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [31:0]     in_x1,
    input  logic [31:0]     in_x2,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_y,
    output logic [TAGW-1:0] out_tag,
    output logic            out_illegal
`ifdef FSGNJ_EXEC_PERF_EN
    ,
    output logic [31:0]     perf_cnt,
    output logic [31:0]     perf_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]     y;
        logic [TAGW-1:0] tag;
        logic            ill;
    } entry_t;

    // Returns {illegal, y}; only the sign bit is ever rewritten.
    function automatic logic [32:0] sgnj(input logic [1:0] op, input logic [31:0] x1,
                                         input logic [31:0] x2);
        logic [32:0] r;
        case (op)
            2'b00:   r = {1'b0, x2[31], x1[30:0]};
            2'b01:   r = {1'b0, ~x2[31], x1[30:0]};
            2'b10:   r = {1'b0, x1[31] ^ x2[31], x1[30:0]};
            default: r = {1'b1, x1};
        endcase
        return r;
    endfunction

    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          alive_q;
    logic          vld_p0, pop;
    logic [32:0]   res_p0;
    entry_t        ent_p0, head;
    entry_t        mem [DEPTH];

    // Stage p0: result formation at accept time
    assign res_p0 = sgnj(in_op, in_x1, in_x2);
    assign ent_p0 = '{y: res_p0[31:0], tag: in_tag, ill: res_p0[32]};

    // alive_q keeps in_ready low throughout reset and until the first edge after it
    assign in_ready  = alive_q && (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign vld_p0    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (vld_p0) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            case ({vld_p0, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage holds data only; emptiness is tracked by count, so no reset is needed here
    always_ff @(posedge clk) begin
        if (vld_p0) mem[wptr] <= ent_p0;
    end

    // Stage p1: head of FIFO drives the outputs, forced to zero when empty
    assign head        = mem[rptr];
    assign out_y       = out_valid ? head.y   : '0;
    assign out_tag     = out_valid ? head.tag : '0;
    assign out_illegal = out_valid && head.ill;

`ifdef FSGNJ_EXEC_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cnt   <= '0;
            perf_stall <= '0;
        end else begin
            if (pop)                   perf_cnt   <= perf_cnt + 32'd1;
            if (in_valid && !in_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
